id_ex_stage: RTL

Decode-to-execute pipeline stage of the 5-stage MIPS core. It registers decoded operands and control, resolves RAW hazards, and drives `SrcAE`, `SrcBE` and `ALUControlE` straight into the ALU. Hazards are resolved by forwarding from MEM/WB or by stalling decode. It also produces the store data and destination register consumed by the EX/MEM register.

---
 rtl/id_ex_stage.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW hazard resolution feeding the ALU.
// ID_EX_FORWARD_EN selects M/W forwarding; undefined, decode stalls on E/M producers.
module id_ex_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned REGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ValidD,
  input  logic [REGW-1:0]  RsD,
  input  logic [REGW-1:0]  RtD,
  input  logic [REGW-1:0]  RdD,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] SignImmD,
  input  logic [4:0]       ShamtD,
  input  logic [3:0]       ALUControlD,
  input  logic             ALUSrcD,
  input  logic             ShiftSrcD,
  input  logic             RegDstD,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             MemWriteD,
  input  logic             FlushE,
  input  logic [WIDTH-1:0] ALUOutM,
  input  logic [REGW-1:0]  WriteRegM,
  input  logic             RegWriteM,
  input  logic [WIDTH-1:0] ResultW,
  input  logic [REGW-1:0]  WriteRegW,
  input  logic             RegWriteW,
  output logic [WIDTH-1:0] SrcAE,
  output logic [WIDTH-1:0] SrcBE,
  output logic [3:0]       ALUControlE,
  output logic [WIDTH-1:0] WriteDataE,
  output logic [REGW-1:0]  WriteRegE,
  output logic             RegWriteE,
  output logic             MemtoRegE,
  output logic             MemWriteE,
  output logic             ValidE,
  output logic             StallD
);

  logic [REGW-1:0]  rs_q, rt_q, rd_q;
  logic [WIDTH-1:0] rd1_q, rd2_q, imm_q;
  logic [4:0]       shamt_q;
  logic [3:0]       alu_ctrl_q;
  logic             alu_src_q, shift_src_q, reg_dst_q;
  logic             reg_write_q, mem_to_reg_q, mem_write_q, valid_q;
  logic [WIDTH-1:0] fwd_a, fwd_b;
  logic [REGW-1:0]  write_reg_e;

  // Data fields are don't-care in a bubble, so they load unconditionally.
  always_ff @(posedge clk) begin
    if (reset) begin
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      shamt_q      <= '0;
      alu_ctrl_q   <= '0;
      alu_src_q    <= 1'b0;
      shift_src_q  <= 1'b0;
      reg_dst_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      rs_q    <= RsD;
      rt_q    <= RtD;
      rd_q    <= RdD;
      rd1_q   <= RD1D;
      rd2_q   <= RD2D;
      imm_q   <= SignImmD;
      shamt_q <= ShamtD;
      if (FlushE || StallD) begin
        alu_ctrl_q   <= '0;
        alu_src_q    <= 1'b0;
        shift_src_q  <= 1'b0;
        reg_dst_q    <= 1'b0;
        reg_write_q  <= 1'b0;
        mem_to_reg_q <= 1'b0;
        mem_write_q  <= 1'b0;
        valid_q      <= 1'b0;
      end else begin
        alu_ctrl_q   <= ALUControlD;
        alu_src_q    <= ALUSrcD;
        shift_src_q  <= ShiftSrcD;
        reg_dst_q    <= RegDstD;
        reg_write_q  <= RegWriteD;
        mem_to_reg_q <= MemtoRegD;
        mem_write_q  <= MemWriteD;
        valid_q      <= ValidD;
      end
    end
  end

  assign write_reg_e = reg_dst_q ? rd_q : rt_q;

`ifdef ID_EX_FORWARD_EN
  always_comb begin
    fwd_a = rd1_q;
    fwd_b = rd2_q;
    if (RegWriteM && (WriteRegM != '0) && (WriteRegM == rs_q)) begin
      fwd_a = ALUOutM;
    end else if (RegWriteW && (WriteRegW != '0) && (WriteRegW == rs_q)) begin
      fwd_a = ResultW;
    end
    if (RegWriteM && (WriteRegM != '0) && (WriteRegM == rt_q)) begin
      fwd_b = ALUOutM;
    end else if (RegWriteW && (WriteRegW != '0) && (WriteRegW == rt_q)) begin
      fwd_b = ResultW;
    end
  end

  // Only a load in E has no value to forward yet.
  assign StallD = ValidD & mem_to_reg_q & reg_write_q & (write_reg_e != '0) &
                  ((write_reg_e == RsD) | (write_reg_e == RtD));
`else
  logic rs_hit, rt_hit;
  logic unused_fwd;

  assign fwd_a = rd1_q;
  assign fwd_b = rd2_q;

  // W is covered by the register file writing before it reads.
  assign rs_hit = (RsD != '0) & ((reg_write_q & (write_reg_e == RsD)) |
                                 (RegWriteM & (WriteRegM == RsD)));
  assign rt_hit = (RtD != '0) & ((reg_write_q & (write_reg_e == RtD)) |
                                 (RegWriteM & (WriteRegM == RtD)));
  assign StallD = ValidD & (rs_hit | rt_hit);

  assign unused_fwd = ^{ALUOutM, ResultW, WriteRegW, RegWriteW, rs_q};
`endif

  // Shifts carry the amount in A and the value to shift in B.
  assign SrcAE       = shift_src_q ? {{(WIDTH-5){1'b0}}, shamt_q} : fwd_a;
  assign SrcBE       = alu_src_q ? imm_q : fwd_b;
  assign WriteDataE  = fwd_b;
  assign WriteRegE   = write_reg_e;
  assign ALUControlE = alu_ctrl_q;
  assign RegWriteE   = reg_write_q;
  assign MemtoRegE   = mem_to_reg_q;
  assign MemWriteE   = mem_write_q;
  assign ValidE      = valid_q;

endmodule
